// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS phase generator.
package dds_pkg;
    localparam int PHASE_W    = 32;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 16;
    localparam int AMP_W      = 16;
    localparam int LEN_W      = 16;
    localparam int ROM_LAT    = 1;
    localparam int PIPE_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;
endpackage

// File: rtl/dds_phase_gen_if.sv
// Control, ROM and sample signals of the DDS block.
// The master side also drives rom_data, since the ROM lives in the parent.
interface dds_phase_gen_if
    import dds_pkg::*;
#(
    parameter int P_W = PHASE_W,
    parameter int A_W = ADDR_W,
    parameter int D_W = DATA_W,
    parameter int M_W = AMP_W,
    parameter int L_W = LEN_W
);
    logic           start;
    logic           stop;
    logic [P_W-1:0] ftw;
    logic [P_W-1:0] poff;
    logic [M_W-1:0] amp;
    logic [L_W-1:0] burst_len;
    logic [A_W-1:0] rom_addr;
    logic [D_W-1:0] rom_data;
    logic [D_W-1:0] sample;
    logic           sample_valid;
    logic           busy;
    logic           done;

    modport master (
        output start, stop, ftw, poff, amp, burst_len, rom_data,
        input  rom_addr, sample, sample_valid, busy, done
    );

    modport slave (
        input  start, stop, ftw, poff, amp, burst_len, rom_data,
        output rom_addr, sample, sample_valid, busy, done
    );
endinterface

// File: rtl/dds_phase_gen_phase_acc.sv
// Phase accumulator: latches tuning word and offset, steps the phase and
// registers the ROM address taken from the top bits of phase + offset.
module phase_acc
    import dds_pkg::*;
#(
    parameter int P_W = PHASE_W,
    parameter int A_W = ADDR_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [P_W-1:0] ftw_i,
    input  logic [P_W-1:0] poff_i,
    output logic [A_W-1:0] addr_o
);
    logic [P_W-1:0] ftw_q, poff_q, acc_q;
    logic [A_W-1:0] addr_q;
    logic [P_W-1:0] phase_sum;
    logic           phase_unused;

    assign phase_sum    = acc_q + poff_q;
    assign phase_unused = ^phase_sum[P_W-A_W-1:0];
    assign addr_o       = addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ftw_q  <= '0;
            poff_q <= '0;
            acc_q  <= '0;
            addr_q <= '0;
        end else if (load_i) begin
            ftw_q  <= ftw_i;
            poff_q <= poff_i;
            acc_q  <= '0;
        end else if (step_i) begin
            // accumulator wraps naturally modulo 2^P_W
            addr_q <= phase_sum[P_W-1 -: A_W];
            acc_q  <= acc_q + ftw_q;
        end
    end
endmodule

// File: rtl/dds_phase_gen.sv
// DDS control FSM, burst counter, ROM-latency valid pipe and amplitude scaling
// around an external registered sine ROM.
module dds_phase_gen
    import dds_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    dds_phase_gen_if.slave  bus
);
    localparam int PROD_W = DATA_W + AMP_W + 1;

    state_t                  state_q;
    logic [LEN_W-1:0]        cnt_q, len_q;
    logic [AMP_W-1:0]        amp_q;
    logic [PIPE_DEPTH-1:0]   vld_pipe_q;   // [0]=address issued, [1]=rom data ready
    logic [PIPE_DEPTH-1:0]   last_pipe_q;
    logic [DATA_W-1:0]       sample_q;
    logic                    sample_valid_q, busy_q, done_q;

    logic                    accept, issue, last_issue, stop_run;
    logic signed [PROD_W-1:0] prod;
    logic                    prod_unused;
    logic [DATA_W-1:0]       sample_d;

    assign accept     = (state_q == IDLE) && bus.start && !bus.stop;
    assign issue      = (state_q == RUN) && !bus.stop;
    assign stop_run   = (state_q == RUN) && bus.stop;
    assign last_issue = issue && (len_q != '0) && (LEN_W'(cnt_q + LEN_W'(1)) == len_q);

    // floor(rom_data * amp / 2^AMP_W); the slice is the arithmetic shift result
    assign prod        = $signed(bus.rom_data) * $signed({1'b0, amp_q});
    assign sample_d    = prod[AMP_W +: DATA_W];
    assign prod_unused = ^{prod[PROD_W-1], prod[AMP_W-1:0]};

    phase_acc #(.P_W(PHASE_W), .A_W(ADDR_W)) u_acc (
        .clk    (clk),
        .reset  (reset),
        .load_i (accept),
        .step_i (issue),
        .ftw_i  (bus.ftw),
        .poff_i (bus.poff),
        .addr_o (bus.rom_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            amp_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    state_q <= RUN;
                    len_q   <= bus.burst_len;
                    amp_q   <= bus.amp;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
                RUN: begin
                    if (issue)
                        cnt_q <= cnt_q + LEN_W'(1);
                    if (stop_run || last_issue)
                        state_q <= DRAIN;
                end
                DRAIN: if (done_q) begin
                    // done is always the last pipe event, so busy falls right after it
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe_q     <= '0;
            last_pipe_q    <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            vld_pipe_q     <= {vld_pipe_q[0], issue};
            // a stop marks whatever is already in the address stage as final,
            // or produces a lone done when nothing was issued yet
            last_pipe_q    <= {last_pipe_q[0] | stop_run, last_issue};
            sample_valid_q <= vld_pipe_q[1];
            done_q         <= last_pipe_q[1];
            if (vld_pipe_q[1])
                sample_q <= sample_d;
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_dds_phase_gen.sv
// Scoreboard bench for dds_phase_gen with a registered sine ROM model.
module tb_dds_phase_gen;
    import dds_pkg::*;

    typedef struct {
        logic [15:0] s;
        logic [7:0]  a;
        logic        d;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dds_phase_gen_if bus ();
    dds_phase_gen dut (.clk(clk), .reset(reset), .bus(bus));

    logic signed [15:0] rom [256];
    initial begin
        for (int i = 0; i < 256; i++)
            rom[i] = 16'(int'(32767.0 * $sin(2.0 * 3.14159265358979 * i / 256.0)));
    end
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: k-th sample reads ROM at top byte of (poff + k*ftw)
    task automatic push_burst(input logic [31:0] f, input logic [31:0] p,
                              input logic [15:0] a, input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] ph;
            logic [7:0]  ad;
            longint      pr;
            exp_t        e;
            ph = p + f * 32'(k);
            ad = ph[31:24];
            pr = longint'(rom[ad]) * longint'(a);
            pr = pr >>> 16;
            e.s = pr[15:0];
            e.a = ad;
            e.d = (k == n - 1);
            q.push_back(e);
        end
    endtask

    task automatic start_run(input logic [31:0] f, input logic [31:0] p,
                             input logic [15:0] a, input logic [15:0] len);
        bus.ftw = f; bus.poff = p; bus.amp = a; bus.burst_len = len;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", {31'd0, ok}, 32'd1);
        chk("queue_drained", q.size(), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"},  {24'd0, bus.rom_addr}, 32'd0);
        chk({tag, "_sample"}, {16'd0, bus.sample}, 32'd0);
        chk({tag, "_valid"}, {31'd0, bus.sample_valid}, 32'd0);
        chk({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, bus.done}, 32'd0);
    endtask

    // Monitor: pops the scoreboard on every sample_valid
    initial begin
        logic [7:0] ah1, ah2;
        logic       prev_done;
        exp_t       e;
        ah1 = '0; ah2 = '0; prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ah1 = '0; ah2 = '0; prev_done = 1'b0;
            end else begin
                if (bus.sample_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_sample", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("sample", {16'd0, bus.sample}, {16'd0, e.s});
                        chk("addr", {24'd0, ah2}, {24'd0, e.a});
                        chk("done", {31'd0, bus.done}, {31'd0, e.d});
                    end
                end else if (bus.done) begin
                    chk("done_without_sample", 32'd1, 32'd0);
                end
                if (bus.done)
                    chk("busy_with_done", {31'd0, bus.busy}, 32'd1);
                if (prev_done)
                    chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
                prev_done = bus.done;
                ah2 = ah1;
                ah1 = bus.rom_addr;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 0; bus.stop = 0; bus.ftw = 0; bus.poff = 0;
        bus.amp = 0; bus.burst_len = 0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2 chk_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // ramp up from address 0
        push_burst(32'h0100_0000, 32'h0, 16'hFFFF, 4);
        start_run(32'h0100_0000, 32'h0, 16'hFFFF, 16'd4);
        wait_idle();

        // quarter-phase offset, half amplitude, negative half-cycle
        push_burst(32'h8000_0000, 32'h4000_0000, 16'h8000, 3);
        start_run(32'h8000_0000, 32'h4000_0000, 16'h8000, 16'd3);
        wait_idle();

        // phase wrap between 0 and 128
        push_burst(32'h8000_0000, 32'h0, 16'hFFFF, 4);
        start_run(32'h8000_0000, 32'h0, 16'hFFFF, 16'd4);
        wait_idle();

        // continuous run, stopped after 10 issues, with an ignored restart
        push_burst(32'h0100_0000, 32'h0, 16'hFFFF, 10);
        start_run(32'h0100_0000, 32'h0, 16'hFFFF, 16'd0);
        repeat (5) @(posedge clk);
        #1;
        start_run(32'h2000_0000, 32'h1000_0000, 16'h0100, 16'd2);
        repeat (4) @(posedge clk);
        #1 bus.stop = 1'b1;
        @(posedge clk);
        #1 bus.stop = 1'b0;
        wait_idle();

        // asynchronous reset in the middle of a run
        push_burst(32'h0100_0000, 32'h0, 16'hFFFF, 20);
        start_run(32'h0100_0000, 32'h0, 16'hFFFF, 16'd20);
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("midrst");
        q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        push_burst(32'h0200_0000, 32'h0, 16'hFFFF, 2);
        start_run(32'h0200_0000, 32'h0, 16'hFFFF, 16'd2);
        wait_idle();

        // start and stop together: stop wins
        bus.start = 1'b1; bus.stop = 1'b1; bus.burst_len = 16'd3;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.stop = 1'b0;
        chk("startstop_busy", {31'd0, bus.busy}, 32'd0);
        repeat (4) @(posedge clk);
        #1 chk("startstop_busy_later", {31'd0, bus.busy}, 32'd0);

        // single-sample burst with exact latency
        push_burst(32'h0300_0000, 32'h2000_0000, 16'h4000, 1);
        start_run(32'h0300_0000, 32'h2000_0000, 16'h4000, 16'd1);
        chk("lat_busy", {31'd0, bus.busy}, 32'd1);
        @(posedge clk); #1;
        chk("lat_addr", {24'd0, bus.rom_addr}, 32'd32);
        chk("lat_v1", {31'd0, bus.sample_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_v2", {31'd0, bus.sample_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_v3", {31'd0, bus.sample_valid}, 32'd1);
        chk("lat_done", {31'd0, bus.done}, 32'd1);
        wait_idle();

        // randomized bursts
        for (int r = 0; r < 8; r++) begin
            logic [31:0] f, p;
            logic [15:0] a;
            int          n;
            f = $urandom; p = $urandom; a = 16'($urandom);
            n = int'($urandom_range(1, 6));
            push_burst(f, p, a, n);
            start_run(f, p, a, 16'(n));
            wait_idle();
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
